// File: rtl/core_irq_timer_pkg.sv
// Shared register map, IRQ mode encoding and MEM response type for core_irq_timer_ctrl.
package core_irq_timer_pkg;

  localparam logic [3:0] REG_PENDING     = 4'h0;
  localparam logic [3:0] REG_ENABLE      = 4'h1;
  localparam logic [3:0] REG_MODE        = 4'h2;
  localparam logic [3:0] REG_MTIME_LO    = 4'h3;
  localparam logic [3:0] REG_MTIME_HI    = 4'h4;
  localparam logic [3:0] REG_MTIMECMP_LO = 4'h5;
  localparam logic [3:0] REG_MTIMECMP_HI = 4'h6;
  localparam logic [3:0] REG_PRESC       = 4'h7;
  localparam logic [3:0] REG_WDOG        = 4'h8;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_e;

  typedef struct packed {
    logic        valid;
    logic        error;
    logic [31:0] rdata;
  } mem_rsp_t;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/core_irq_timer_ctrl_irq_sync_edge.sv
// SYNC_STAGES-flop synchroniser plus rising-edge detect for one async IRQ source.
// Latency: level SYNC_STAGES cycles, rise pulse valid in the same cycle as the new level; no backpressure.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level_o = r_sync[SYNC_STAGES-1];
  assign rise_o  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/core_irq_timer_ctrl.sv
// IRQ capture, prescaled 64-bit mtime/mtimecmp and optional watchdog NMI (CORE_IRQ_TIMER_CTRL_WDOG_EN).
// MEM slave: grant same cycle, registered response next cycle, accepts a request every cycle.
module core_irq_timer_ctrl
  import core_irq_timer_pkg::*;
#(
  parameter int unsigned        NUM_IRQ     = 8,
  parameter int unsigned        DATA_WIDTH  = 32,
  parameter int unsigned        ADDR_WIDTH  = 32,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '1,
  parameter logic [30:0]        NMI_VEC     = 31'h20000000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_req_i,
  output logic                  mem_gnt_o,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [3:0]            mem_be_i,
  output logic                  mem_valid_o,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_error_o,
  input  logic [NUM_IRQ-1:0]    irq_src_i,
  output logic [NUM_IRQ-1:0]    extintsrc_req_o,
  output logic                  timer_int_o,
  output logic                  nmi_int_o,
  output logic [30:0]           nmi_vec_o
);

  logic [3:0]         w_idx;
  logic               w_wr;
  logic [31:0]        w_bmask;
  logic [31:0]        w_wdat_m;
  logic [31:0]        w_rdata;
  logic               w_err;
  logic               w_unused_addr;
  logic [NUM_IRQ-1:0] w_sync, w_edge, w_clr, w_pend_nxt;
  logic               w_tick;

  logic [NUM_IRQ-1:0] r_pending, r_enable, r_mode, r_req;
  logic [31:0]        r_presc, r_presc_cnt;
  logic [63:0]        r_mtime, r_mtimecmp;
  logic               r_timer_int;
  mem_rsp_t           r_rsp;

  assign w_idx         = mem_addr_i[5:2];
  assign w_unused_addr = ^{mem_addr_i[ADDR_WIDTH-1:6], mem_addr_i[1:0]};
  assign w_wr          = mem_req_i & mem_we_i;
  assign w_bmask       = be_mask(mem_be_i);
  assign w_wdat_m      = mem_wdata_i & w_bmask;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .irq_i   (irq_src_i[g]),
      .level_o (w_sync[g]),
      .rise_o  (w_edge[g])
    );
  end

  // A new edge in the same cycle as a W1C keeps the bit set; level sources ignore W1C.
  assign w_clr = (w_wr && w_idx == REG_PENDING) ? w_wdat_m[NUM_IRQ-1:0] : '0;

  always_comb begin
    w_pend_nxt = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_mode_e'(r_mode[i]) == IRQ_EDGE) w_pend_nxt[i] = (r_pending[i] & ~w_clr[i]) | w_edge[i];
      else                                    w_pend_nxt[i] = w_sync[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending <= '0;
      r_enable  <= '0;
      r_mode    <= EDGE_MASK;
      r_req     <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_req     <= r_pending & r_enable;
      if (w_wr && w_idx == REG_ENABLE)
        r_enable <= (r_enable & ~w_bmask[NUM_IRQ-1:0]) | w_wdat_m[NUM_IRQ-1:0];
      if (w_wr && w_idx == REG_MODE)
        r_mode <= (r_mode & ~w_bmask[NUM_IRQ-1:0]) | w_wdat_m[NUM_IRQ-1:0];
    end
  end

  assign w_tick = (r_presc_cnt == r_presc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_presc     <= '0;
      r_presc_cnt <= '0;
      r_mtime     <= '0;
      r_mtimecmp  <= '1;
      r_timer_int <= 1'b0;
    end else begin
      if (w_wr && w_idx == REG_PRESC) begin
        r_presc     <= (r_presc & ~w_bmask) | w_wdat_m;
        r_presc_cnt <= '0;
      end else begin
        r_presc_cnt <= w_tick ? '0 : r_presc_cnt + 32'd1;
      end
      // A software write to either mtime half suppresses that cycle's increment.
      if (w_wr && (w_idx == REG_MTIME_LO || w_idx == REG_MTIME_HI)) begin
        if (w_idx == REG_MTIME_LO) r_mtime[31:0]  <= (r_mtime[31:0] & ~w_bmask) | w_wdat_m;
        else                       r_mtime[63:32] <= (r_mtime[63:32] & ~w_bmask) | w_wdat_m;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
      if (w_wr && w_idx == REG_MTIMECMP_LO)
        r_mtimecmp[31:0] <= (r_mtimecmp[31:0] & ~w_bmask) | w_wdat_m;
      if (w_wr && w_idx == REG_MTIMECMP_HI)
        r_mtimecmp[63:32] <= (r_mtimecmp[63:32] & ~w_bmask) | w_wdat_m;
      r_timer_int <= (r_mtime >= r_mtimecmp);
    end
  end

`ifdef CORE_IRQ_TIMER_CTRL_WDOG_EN
  logic [31:0] r_wdog_cnt;
  logic        r_wdog_armed;
  logic        r_nmi;
  logic [31:0] w_wdog_new;

  assign w_wdog_new = (r_wdog_cnt & ~w_bmask) | w_wdat_m;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wdog_cnt   <= '0;
      r_wdog_armed <= 1'b0;
      r_nmi        <= 1'b0;
    end else if (w_wr && w_idx == REG_WDOG) begin
      r_wdog_cnt   <= w_wdog_new;
      r_wdog_armed <= |w_wdog_new;
      r_nmi        <= 1'b0;
    end else if (r_wdog_armed && w_tick) begin
      r_wdog_cnt <= r_wdog_cnt - 32'd1;
      if (r_wdog_cnt == 32'd1) begin
        r_nmi        <= 1'b1;
        r_wdog_armed <= 1'b0;
      end
    end
  end

  assign nmi_int_o = r_nmi;
`else
  assign nmi_int_o = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (w_idx)
      REG_PENDING:     w_rdata = 32'(r_pending);
      REG_ENABLE:      w_rdata = 32'(r_enable);
      REG_MODE:        w_rdata = 32'(r_mode);
      REG_MTIME_LO:    w_rdata = r_mtime[31:0];
      REG_MTIME_HI:    w_rdata = r_mtime[63:32];
      REG_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      REG_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      REG_PRESC:       w_rdata = r_presc;
`ifdef CORE_IRQ_TIMER_CTRL_WDOG_EN
      REG_WDOG:        w_rdata = r_wdog_cnt;
`endif
      default:         w_err   = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp <= '0;
    end else begin
      r_rsp.valid <= mem_req_i;
      r_rsp.error <= mem_req_i & w_err;
      r_rsp.rdata <= (mem_req_i && !mem_we_i) ? w_rdata : '0;
    end
  end

  assign mem_gnt_o       = mem_req_i;
  assign mem_valid_o     = r_rsp.valid;
  assign mem_error_o     = r_rsp.error;
  assign mem_rdata_o     = r_rsp.rdata;
  assign extintsrc_req_o = r_req;
  assign timer_int_o     = r_timer_int;
  assign nmi_vec_o       = NMI_VEC;

endmodule

// File: tb/tb_core_irq_timer_ctrl.sv
// Randomised scenario bench for core_irq_timer_ctrl against a cycle-count reference model.
module tb_core_irq_timer_ctrl;

  localparam int N   = 8;
  localparam int LAT = 2 + 2;
  localparam logic [31:0] A_PEND = 32'h00, A_EN = 32'h04, A_MODE = 32'h08, A_MTL = 32'h0C,
                          A_MTH = 32'h10, A_CML = 32'h14, A_CMH = 32'h18, A_PRESC = 32'h1C,
                          A_WDOG = 32'h20;
  localparam logic [31:0] IRQ_MASK = 32'h0000_00FF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_req, mem_gnt, mem_we, mem_valid, mem_error;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_be;
  logic [N-1:0]  irq_src, extint;
  logic          timer_int, nmi_int;
  logic [30:0]   nmi_vec;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_irq_timer_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_req_i(mem_req), .mem_gnt_o(mem_gnt), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_be_i(mem_be), .mem_valid_o(mem_valid),
    .mem_rdata_o(mem_rdata), .mem_error_o(mem_error), .irq_src_i(irq_src),
    .extintsrc_req_o(extint), .timer_int_o(timer_int), .nmi_int_o(nmi_int), .nmi_vec_o(nmi_vec)
  );

  // Bus tasks start and end at a falling edge; the write lands on the rising edge in between.
  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d; mem_be = be;
    @(negedge clk);
    mem_req = 1'b0; mem_we = 1'b0;
  endtask

  task automatic mem_read(input logic [31:0] a, output logic [31:0] d, output logic e, output logic v);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = a; mem_be = 4'hF;
    @(negedge clk);
    mem_req = 1'b0;
    d = mem_rdata; e = mem_error; v = mem_valid;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e, v;
    logic [31:0] addrs [5] = '{A_CML, A_CMH, A_MODE, A_EN, A_PRESC};
    logic [31:0] exps  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, IRQ_MASK, 32'h0, 32'h0};
    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0; irq_src = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (extint !== '0 || timer_int !== 1'b0 || nmi_int !== 1'b0 || mem_valid !== 1'b0 || mem_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outs: ext=%h tmr=%b nmi=%b vld=%b gnt=%b want all 0", extint, timer_int, nmi_int, mem_valid, mem_gnt);
    end
    n_cmp++;
    if (nmi_vec !== 31'h20000000) begin
      n_bad++; $display("FAIL reset_nmi_vec: got %h want 20000000", nmi_vec);
    end
    for (int i = 0; i < 5; i++) begin
      mem_read(addrs[i], d, e, v);
      n_cmp++;
      if (d !== exps[i] || e !== 1'b0 || v !== 1'b1) begin
        n_bad++; $display("FAIL reset_reg_%h: rdata=%h err=%b vld=%b want %h/0/1", addrs[i], d, e, v, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    r1 = $urandom; r2 = $urandom;
    mem_write(A_EN, r1, 4'hF);
    mem_write(A_MODE, r2, 4'hF);
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = A_EN;
    #1;
    n_cmp++;
    if (mem_gnt !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt: got %b want 1", mem_gnt); end
    @(negedge clk);
    n_cmp++;
    if (mem_valid !== 1'b1 || mem_rdata !== (r1 & IRQ_MASK)) begin
      n_bad++; $display("FAIL b2b_enable: vld=%b rdata=%h want 1/%h", mem_valid, mem_rdata, r1 & IRQ_MASK);
    end
    mem_addr = A_MODE;
    @(negedge clk);
    mem_req = 1'b0;
    n_cmp++;
    if (mem_valid !== 1'b1 || mem_rdata !== (r2 & IRQ_MASK)) begin
      n_bad++; $display("FAIL b2b_mode: vld=%b rdata=%h want 1/%h", mem_valid, mem_rdata, r2 & IRQ_MASK);
    end
    @(negedge clk);
    n_cmp++;
    if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_vld: got %b want 0", mem_valid); end
    mem_write(A_MODE, 32'hFF, 4'hF);
    mem_write(A_EN, 32'h0, 4'hF);
  endtask

  task automatic test_byte_enable();
    logic [31:0] d, got, expv; logic [3:0] be; logic e, v;
    for (int t = 0; t < 3; t++) begin
      d = $urandom; be = 4'($urandom_range(1, 15));
      expv = '0;
      for (int b = 0; b < 4; b++) if (be[b]) expv[b*8 +: 8] = d[b*8 +: 8];
      mem_write(A_PRESC, 32'h0, 4'hF);
      mem_write(A_PRESC, d, be);
      mem_read(A_PRESC, got, e, v);
      n_cmp++;
      if (got !== expv || e !== 1'b0) begin
        n_bad++; $display("FAIL byte_en_%0d: rdata=%h err=%b want %h/0 (be=%b)", t, got, e, expv, be);
      end
    end
    mem_write(A_PRESC, 32'h0, 4'hF);
  endtask

  task automatic test_edge_irq();
    int k; logic [31:0] bitv, d; logic e, v;
    k = $urandom_range(0, N-1);
    bitv = 32'h1 << k;
    mem_write(A_EN, bitv, 4'hF);
    irq_src[k] = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (c == 1) irq_src[k] = 1'b0;
      n_cmp++;
      if (extint[k] !== (c >= LAT)) begin
        n_bad++; $display("FAIL edge_lat_c%0d: req[%0d]=%b want %b", c, k, extint[k], c >= LAT);
      end
    end
    mem_read(A_PEND, d, e, v);
    n_cmp++;
    if (d !== bitv) begin n_bad++; $display("FAIL edge_pending: got %h want %h", d, bitv); end
    mem_write(A_PEND, bitv, 4'hF);
    mem_read(A_PEND, d, e, v);
    n_cmp++;
    if (d !== 32'h0 || extint[k] !== 1'b0) begin
      n_bad++; $display("FAIL edge_w1c: pending=%h req=%b want 0/0", d, extint[k]);
    end
    irq_src[k] = 1'b1;
    @(negedge clk);
    irq_src[k] = 1'b0;
    @(negedge clk);
    mem_write(A_PEND, bitv, 4'hF);
    mem_read(A_PEND, d, e, v);
    n_cmp++;
    if (d !== bitv) begin n_bad++; $display("FAIL edge_set_wins: pending=%h want %h", d, bitv); end
    mem_write(A_PEND, bitv, 4'hF);
    mem_write(A_EN, 32'h0, 4'hF);
  endtask

  task automatic test_level_irq();
    int k; logic [31:0] bitv, d; logic e, v;
    k = $urandom_range(0, N-1);
    bitv = 32'h1 << k;
    mem_write(A_MODE, IRQ_MASK & ~bitv, 4'hF);
    mem_write(A_EN, bitv, 4'hF);
    irq_src[k] = 1'b1;
    repeat (LAT) @(negedge clk);
    n_cmp++;
    if (extint[k] !== 1'b1) begin n_bad++; $display("FAIL level_high: req[%0d]=%b want 1", k, extint[k]); end
    mem_write(A_PEND, bitv, 4'hF);
    mem_read(A_PEND, d, e, v);
    n_cmp++;
    if (d !== bitv) begin n_bad++; $display("FAIL level_w1c_ignored: pending=%h want %h", d, bitv); end
    irq_src[k] = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      n_cmp++;
      if (extint[k] !== (c < LAT)) begin
        n_bad++; $display("FAIL level_drop_c%0d: req[%0d]=%b want %b", c, k, extint[k], c < LAT);
      end
    end
    mem_write(A_MODE, IRQ_MASK, 4'hF);
    mem_write(A_EN, 32'h0, 4'hF);
  endtask

  task automatic test_timer();
    int p, c, first; logic [31:0] d; logic e, v;
    p = $urandom_range(0, 5); c = $urandom_range(1, 6);
    // After the PRESC write, mtime after n edges is n/(p+1); timer_int lags mtime by one edge.
    first = c * (p + 1) + 1;
    mem_write(A_PRESC, 32'hFFFF_FFFF, 4'hF);
    mem_write(A_MTL, 32'h0, 4'hF);
    mem_write(A_MTH, 32'h0, 4'hF);
    mem_write(A_CMH, 32'h0, 4'hF);
    mem_write(A_CML, 32'(c), 4'hF);
    mem_write(A_PRESC, 32'(p), 4'hF);
    repeat (first - 1) @(negedge clk);
    n_cmp++;
    if (timer_int !== 1'b0) begin n_bad++; $display("FAIL timer_early: got %b want 0 (p=%0d c=%0d)", timer_int, p, c); end
    @(negedge clk);
    n_cmp++;
    if (timer_int !== 1'b1) begin n_bad++; $display("FAIL timer_rise: got %b want 1 (p=%0d c=%0d)", timer_int, p, c); end
    mem_read(A_MTL, d, e, v);
    n_cmp++;
    if (d !== 32'(first / (p + 1))) begin n_bad++; $display("FAIL timer_mtime: got %h want %h", d, 32'(first / (p + 1))); end
    mem_write(A_CMH, 32'h1, 4'hF);
    n_cmp++;
    if (timer_int !== 1'b1) begin n_bad++; $display("FAIL timer_hold: got %b want 1", timer_int); end
    @(negedge clk);
    n_cmp++;
    if (timer_int !== 1'b0) begin n_bad++; $display("FAIL timer_fall: got %b want 0", timer_int); end
  endtask

  task automatic test_wrap_unmapped();
    logic [63:0] base; logic [63:0] m; logic [31:0] d, r; logic e, v;
    base = '1;
    mem_write(A_PRESC, 32'hFFFF_FFFF, 4'hF);
    mem_write(A_MTL, 32'hFFFF_FFFF, 4'hF);
    mem_write(A_MTH, 32'hFFFF_FFFF, 4'hF);
    mem_write(A_PRESC, 32'h0, 4'hF);
    mem_read(A_MTH, d, e, v);
    m = base;
    n_cmp++;
    if (d !== m[63:32]) begin n_bad++; $display("FAIL wrap_hi_pre: got %h want %h", d, m[63:32]); end
    mem_read(A_MTL, d, e, v);
    m = base + 64'd1;
    n_cmp++;
    if (d !== m[31:0]) begin n_bad++; $display("FAIL wrap_lo: got %h want %h", d, m[31:0]); end
    mem_read(A_MTH, d, e, v);
    m = base + 64'd2;
    n_cmp++;
    if (d !== m[63:32]) begin n_bad++; $display("FAIL wrap_hi_post: got %h want %h", d, m[63:32]); end
    r = $urandom;
    mem_write(A_MTL, r, 4'hF);
    mem_read(A_MTL, d, e, v);
    n_cmp++;
    if (d !== r) begin n_bad++; $display("FAIL mtime_write_wins: got %h want %h", d, r); end
    mem_read(32'h24, d, e, v);
    n_cmp++;
    if (d !== 32'h0 || e !== 1'b1 || v !== 1'b1) begin
      n_bad++; $display("FAIL unmapped_rd: rdata=%h err=%b vld=%b want 0/1/1", d, e, v);
    end
    mem_write(32'h3C, $urandom, 4'hF);
    n_cmp++;
    if (mem_error !== 1'b1 || mem_valid !== 1'b1) begin
      n_bad++; $display("FAIL unmapped_wr: err=%b vld=%b want 1/1", mem_error, mem_valid);
    end
  endtask

  task automatic test_wdog();
    logic [31:0] d; logic e, v;
`ifdef CORE_IRQ_TIMER_CTRL_WDOG_EN
    mem_write(A_PRESC, 32'h0, 4'hF);
    mem_write(A_WDOG, 32'd10, 4'hF);
    repeat (9) @(negedge clk);
    n_cmp++;
    if (nmi_int !== 1'b0) begin n_bad++; $display("FAIL wdog_early: got %b want 0", nmi_int); end
    @(negedge clk);
    n_cmp++;
    if (nmi_int !== 1'b1) begin n_bad++; $display("FAIL wdog_fire: got %b want 1", nmi_int); end
    mem_write(A_WDOG, 32'd10, 4'hF);
    n_cmp++;
    if (nmi_int !== 1'b0) begin n_bad++; $display("FAIL wdog_kick: got %b want 0", nmi_int); end
    mem_read(A_WDOG, d, e, v);
    n_cmp++;
    if (d !== 32'd10 || e !== 1'b0) begin n_bad++; $display("FAIL wdog_read: rdata=%h err=%b want a/0", d, e); end
    mem_write(A_WDOG, 32'h0, 4'hF);
`else
    mem_read(A_WDOG, d, e, v);
    n_cmp++;
    if (d !== 32'h0 || e !== 1'b1) begin n_bad++; $display("FAIL wdog_unmapped: rdata=%h err=%b want 0/1", d, e); end
    n_cmp++;
    if (nmi_int !== 1'b0) begin n_bad++; $display("FAIL nmi_tied: got %b want 0", nmi_int); end
`endif
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d; logic e, v;
    mem_write(A_MODE, 32'h0, 4'hF);
    mem_write(A_EN, IRQ_MASK, 4'hF);
    mem_write(A_CMH, 32'h0, 4'hF);
    mem_write(A_CML, 32'h0, 4'hF);
    irq_src = '1;
    repeat (LAT + 1) @(negedge clk);
    n_cmp++;
    if (extint !== 8'hFF || timer_int !== 1'b1) begin
      n_bad++; $display("FAIL midrun_pre: ext=%h tmr=%b want ff/1", extint, timer_int);
    end
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = A_MODE;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (extint !== '0 || timer_int !== 1'b0 || nmi_int !== 1'b0 || mem_valid !== 1'b0 ||
        mem_rdata !== 32'h0 || mem_error !== 1'b0 || nmi_vec !== 31'h20000000) begin
      n_bad++; $display("FAIL midrun_async: ext=%h tmr=%b nmi=%b vld=%b rd=%h err=%b vec=%h want 0s/20000000",
                        extint, timer_int, nmi_int, mem_valid, mem_rdata, mem_error, nmi_vec);
    end
    mem_req = 1'b0; irq_src = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_read(A_CML, d, e, v);
    n_cmp++;
    if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL midrun_cmp: got %h want ffffffff", d); end
    mem_read(A_MODE, d, e, v);
    n_cmp++;
    if (d !== IRQ_MASK) begin n_bad++; $display("FAIL midrun_mode: got %h want %h", d, IRQ_MASK); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_enable();
    test_edge_irq();
    test_level_irq();
    test_timer();
    test_wrap_unmapped();
    test_wdog();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule
